uart_bus_arbiter: RTL and testbench

Two-master arbiter and bus sequencer for the UART slave port (address/data/wr/enable/ready). Lets the CPU data port (master 0) and the debug/boot loader (master 1) share one UART instance. Serialises transactions with round-robin fairness and guarantees the enable/ready pulse discipline the UART FIFOs need: exactly one enqueue or dequeue per access. Includes a watchdog timeout so a hung slave cannot stall a master.

---
 rtl/uart_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_arbiter
// Brief    : Two-master round-robin arbiter and bus sequencer for a UART slave
//            port, with a watchdog timeout on the slave handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic       clk,
    input  logic       rst,
    // master 0 (CPU data port)
    input  logic [2:0] m0_address,
    input  logic [7:0] m0_data_i,
    input  logic       m0_wr,
    input  logic       m0_enable,
    output logic [7:0] m0_data_o,
    output logic       m0_ready,
    output logic       m0_err,
    // master 1 (debug / boot loader)
    input  logic [2:0] m1_address,
    input  logic [7:0] m1_data_i,
    input  logic       m1_wr,
    input  logic       m1_enable,
    output logic [7:0] m1_data_o,
    output logic       m1_ready,
    output logic       m1_err,
    // UART slave port
    output logic [2:0] uart_address,
    output logic [7:0] uart_data_o,
    output logic       uart_wr,
    output logic       uart_enable,
    input  logic [7:0] uart_data_i,
    input  logic       uart_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nx;
    logic                 r_grant;
    logic                 w_grant_nx;
    logic                 r_last_grant;
    logic                 w_last_grant_nx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nx;

    logic [2:0]           w_uart_address_nx;
    logic [7:0]           w_uart_data_o_nx;
    logic                 w_uart_wr_nx;
    logic                 w_uart_enable_nx;
    logic [1:0]           w_ready_nx;
    logic [1:0]           w_err_nx;
    logic [7:0]           w_m0_data_nx;
    logic [7:0]           w_m1_data_nx;

    logic                 w_winner;
    logic                 w_timeout;
    logic                 w_grant_enable;
    logic [7:0]           w_rsp_data;

    // Tie goes to the master that was not served last; otherwise the lone requester.
    assign w_winner       = (m0_enable && m1_enable) ? ~r_last_grant : ~m0_enable;
    assign w_timeout      = (r_cnt == C_CNT_LAST);
    assign w_grant_enable = r_grant ? m1_enable : m0_enable;
    assign w_rsp_data     = (uart_ready && !uart_wr) ? uart_data_i : 8'h00;

    always_comb begin
        w_state_nx        = r_state;
        w_grant_nx        = r_grant;
        w_last_grant_nx   = r_last_grant;
        w_cnt_nx          = r_cnt;
        w_uart_address_nx = uart_address;
        w_uart_data_o_nx  = uart_data_o;
        w_uart_wr_nx      = uart_wr;
        w_uart_enable_nx  = uart_enable;
        w_ready_nx        = 2'b00;
        w_err_nx          = 2'b00;
        w_m0_data_nx      = m0_data_o;
        w_m1_data_nx      = m1_data_o;

        case (r_state)
            ST_IDLE: begin
                if (m0_enable || m1_enable) begin
                    w_grant_nx        = w_winner;
                    w_uart_address_nx = w_winner ? m1_address : m0_address;
                    w_uart_data_o_nx  = w_winner ? m1_data_i  : m0_data_i;
                    w_uart_wr_nx      = w_winner ? m1_wr      : m0_wr;
                    w_uart_enable_nx  = 1'b1;
                    w_cnt_nx          = '0;
                    w_state_nx        = ST_BUSY;
                end
            end

            ST_BUSY: begin
                w_cnt_nx = r_cnt + C_CNT_ONE;
                // A ready in the same cycle as the timeout still completes normally.
                if (uart_ready || w_timeout) begin
                    w_uart_enable_nx     = 1'b0;
                    w_ready_nx[r_grant]  = 1'b1;
                    w_err_nx[r_grant]    = ~uart_ready;
                    w_last_grant_nx      = r_grant;
                    w_state_nx           = ST_RELEASE;
                    if (r_grant) begin
                        w_m1_data_nx = w_rsp_data;
                    end else begin
                        w_m0_data_nx = w_rsp_data;
                    end
                end
            end

            ST_RELEASE: begin
                // Wait for the served master to drop its request so it is not re-granted.
                if (!w_grant_enable) begin
                    w_state_nx = ST_IDLE;
                end
            end

            default: begin
                w_state_nx       = ST_IDLE;
                w_uart_enable_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            uart_address <= 3'd0;
            uart_data_o  <= 8'h00;
            uart_wr      <= 1'b0;
            uart_enable  <= 1'b0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_err       <= 1'b0;
            m1_err       <= 1'b0;
            m0_data_o    <= 8'h00;
            m1_data_o    <= 8'h00;
        end else begin
            r_state      <= w_state_nx;
            r_grant      <= w_grant_nx;
            r_last_grant <= w_last_grant_nx;
            r_cnt        <= w_cnt_nx;
            uart_address <= w_uart_address_nx;
            uart_data_o  <= w_uart_data_o_nx;
            uart_wr      <= w_uart_wr_nx;
            uart_enable  <= w_uart_enable_nx;
            m0_ready     <= w_ready_nx[0];
            m1_ready     <= w_ready_nx[1];
            m0_err       <= w_err_nx[0];
            m1_err       <= w_err_nx[1];
            m0_data_o    <= w_m0_data_nx;
            m1_data_o    <= w_m1_data_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_arbiter
// Brief    : Scoreboard bench for uart_bus_arbiter with a behavioural UART slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0][2:0] maddr = '0;
    logic [1:0][7:0] mdin  = '0;
    logic [1:0]      mwr   = '0;
    logic [1:0]      men   = '0;
    logic [1:0][7:0] mdout;
    logic [1:0]      mrdy;
    logic [1:0]      merr;
    logic [2:0]      uart_address;
    logic [7:0]      uart_data_o;
    logic            uart_wr;
    logic            uart_enable;
    logic [7:0]      uart_data_i = 8'h00;
    logic            uart_ready  = 1'b0;

    always #5 clk = ~clk;

    uart_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .m0_address(maddr[0]), .m0_data_i(mdin[0]), .m0_wr(mwr[0]), .m0_enable(men[0]),
        .m0_data_o(mdout[0]), .m0_ready(mrdy[0]), .m0_err(merr[0]),
        .m1_address(maddr[1]), .m1_data_i(mdin[1]), .m1_wr(mwr[1]), .m1_enable(men[1]),
        .m1_data_o(mdout[1]), .m1_ready(mrdy[1]), .m1_err(merr[1]),
        .uart_address(uart_address), .uart_data_o(uart_data_o), .uart_wr(uart_wr),
        .uart_enable(uart_enable), .uart_data_i(uart_data_i), .uart_ready(uart_ready)
    );

    typedef struct { logic [2:0] a; logic [7:0] d; logic w; } acc_t;
    typedef struct { int m; logic [7:0] data; logic err; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rises    = 0;
    int high_len = 0;
    int low_len  = 100;
    int last_rise_cyc = 0;
    int req_cyc[2];
    int rdy_cyc[2];
    int drop_cyc[2];
    bit had_access = 1'b0;
    bit respond_en = 1'b1;
    bit responded  = 1'b0;
    logic       prev_en = 1'b0;
    logic [1:0] prev_rdy = 2'b00;
    logic       uart_en_was;
    acc_t       acc_cur;
    rsp_t       rsp_cur;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] uart_rd(input logic [2:0] a);
        return 8'h04 + {5'd0, a};
    endfunction

    always @(posedge clk) cyc++;

    // UART slave: answers one cycle after it sees enable, with a one-cycle ready.
    always @(posedge clk) begin
        uart_en_was = uart_enable;
        #1;
        if (uart_ready) begin
            uart_ready = 1'b0;
        end else if (uart_en_was && respond_en && !responded) begin
            uart_data_i = uart_rd(uart_address);
            uart_ready  = 1'b1;
            responded   = 1'b1;
        end
        if (!uart_en_was) responded = 1'b0;
    end

    always @(negedge clk) begin
        if (uart_enable && !prev_en) begin
            rises++;
            if (had_access) check_eq("enable_gap", 32'(low_len >= 2), 32'd1);
            had_access    = 1'b1;
            last_rise_cyc = cyc;
            high_len      = 0;
            check_eq("acc_expected", 32'(acc_q.size() != 0), 32'd1);
            if (acc_q.size() != 0) begin
                acc_cur = acc_q.pop_front();
                check_eq("uart_address", 32'(uart_address), 32'(acc_cur.a));
                check_eq("uart_data_o",  32'(uart_data_o),  32'(acc_cur.d));
                check_eq("uart_wr",      32'(uart_wr),      32'(acc_cur.w));
            end
        end
        if (uart_enable) begin
            high_len++;
            low_len = 0;
        end else begin
            low_len++;
        end
        for (int m = 0; m < 2; m++) begin
            if (mrdy[m]) begin
                check_eq("ready_pulse", 32'(prev_rdy[m]), 32'd0);
                check_eq("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    rsp_cur = rsp_q.pop_front();
                    check_eq("rsp_master", 32'(m), 32'(rsp_cur.m));
                    check_eq("rsp_data", 32'(mdout[m]), 32'(rsp_cur.data));
                    check_eq("rsp_err", 32'(merr[m]), 32'(rsp_cur.err));
                end
            end else if (merr[m]) begin
                check_eq("err_without_ready", 32'(merr[m]), 32'd0);
            end
        end
        prev_en  = uart_enable;
        prev_rdy = mrdy;
    end

    task automatic expect_txn(input int m, input logic [2:0] a, input logic w,
                              input logic [7:0] d, input logic err);
        acc_t ac;
        rsp_t rs;
        ac.a = a; ac.d = d; ac.w = w;
        rs.m = m; rs.err = err;
        rs.data = (err || w) ? 8'h00 : uart_rd(a);
        acc_q.push_back(ac);
        rsp_q.push_back(rs);
    endtask

    task automatic master_txn(input int m, input logic [2:0] a, input logic w,
                              input logic [7:0] d, input int hold);
        int  t;
        bit  got;
        @(posedge clk); #1;
        maddr[m] = a; mwr[m] = w; mdin[m] = d; men[m] = 1'b1;
        req_cyc[m] = cyc;
        got = 1'b0;
        t   = 0;
        while (t < 100 && !got) begin
            @(negedge clk);
            if (mrdy[m]) begin
                got = 1'b1;
                rdy_cyc[m] = cyc;
            end
            t++;
        end
        check_eq("ready_seen", 32'(got), 32'd1);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        men[m] = 1'b0;
        drop_cyc[m] = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int r0;
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", 32'({uart_enable, uart_wr, uart_address, uart_data_o, mrdy, merr}), 32'd0);
        check_eq("reset_data", 32'(mdout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // single write, uncontended latency
        r0 = rises;
        expect_txn(0, 3'd0, 1'b1, 8'h5A, 1'b0);
        master_txn(0, 3'd0, 1'b1, 8'h5A, 0);
        check_eq("write_latency", 32'(rdy_cyc[0] - req_cyc[0]), 32'd3);
        check_eq("write_enable_len", 32'(high_len), 32'd2);
        check_eq("write_one_access", 32'(rises - r0), 32'd1);

        // single read from master 1
        expect_txn(1, 3'd3, 1'b0, 8'h00, 1'b0);
        master_txn(1, 3'd3, 1'b0, 8'h00, 0);
        check_eq("read_data", 32'(mdout[1]), 32'h07);
        check_eq("m0_untouched", 32'(mdout[0]), 32'h00);

        // contention: both masters request back to back
        expect_txn(0, 3'd1, 1'b1, 8'h11, 1'b0);
        expect_txn(1, 3'd2, 1'b0, 8'hA2, 1'b0);
        expect_txn(0, 3'd4, 1'b1, 8'h22, 1'b0);
        expect_txn(1, 3'd6, 1'b0, 8'hB6, 1'b0);
        fork
            begin
                master_txn(0, 3'd1, 1'b1, 8'h11, 0);
                master_txn(0, 3'd4, 1'b1, 8'h22, 0);
            end
            begin
                master_txn(1, 3'd2, 1'b0, 8'hA2, 0);
                master_txn(1, 3'd6, 1'b0, 8'hB6, 0);
            end
        join

        // held enable keeps the arbiter in RELEASE
        r0 = rises;
        expect_txn(0, 3'd7, 1'b1, 8'h99, 1'b0);
        expect_txn(1, 3'd5, 1'b1, 8'h66, 1'b0);
        fork
            master_txn(0, 3'd7, 1'b1, 8'h99, 5);
            begin
                repeat (3) @(posedge clk);
                master_txn(1, 3'd5, 1'b1, 8'h66, 0);
            end
        join
        check_eq("held_accesses", 32'(rises - r0), 32'd2);
        check_eq("held_resume", 32'(last_rise_cyc - drop_cyc[0]), 32'd2);

        // watchdog timeout, then a normal access
        respond_en = 1'b0;
        expect_txn(0, 3'd2, 1'b1, 8'h33, 1'b1);
        master_txn(0, 3'd2, 1'b1, 8'h33, 0);
        check_eq("timeout_latency", 32'(rdy_cyc[0] - req_cyc[0]), 32'd9);
        check_eq("timeout_enable_len", 32'(high_len), 32'd8);
        respond_en = 1'b1;
        expect_txn(0, 3'd1, 1'b0, 8'h00, 1'b0);
        master_txn(0, 3'd1, 1'b0, 8'h00, 0);
        check_eq("post_timeout_latency", 32'(rdy_cyc[0] - req_cyc[0]), 32'd3);

        // asynchronous reset in the middle of an access
        respond_en = 1'b0;
        acc_cur.a = 3'd5; acc_cur.d = 8'hC3; acc_cur.w = 1'b1;
        acc_q.push_back(acc_cur);
        @(posedge clk); #1;
        maddr[0] = 3'd5; mwr[0] = 1'b1; mdin[0] = 8'hC3; men[0] = 1'b1;
        t = 0;
        while (t < 20 && !uart_enable) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_busy_enable", 32'(uart_enable), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_enable", 32'(uart_enable), 32'd0);
        check_eq("async_reset_outs", 32'({uart_wr, uart_address, uart_data_o, mrdy, merr, mdout}), 32'd0);
        men[0] = 1'b0;
        respond_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;

        expect_txn(0, 3'd6, 1'b1, 8'h44, 1'b0);
        expect_txn(1, 3'd7, 1'b0, 8'h00, 1'b0);
        fork
            master_txn(0, 3'd6, 1'b1, 8'h44, 0);
            master_txn(1, 3'd7, 1'b0, 8'h00, 0);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("scoreboard_drained", 32'(acc_q.size() + rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
